// File: rtl/hub75_pkg.sv
// Shared types and geometry for the HUB75 64x64 scan controller.
package hub75_pkg;

    localparam int unsigned PANEL_W    = 64;
    localparam int unsigned PANEL_ROWS = 32;
    localparam int unsigned FRAME_W    = 13;
    localparam int unsigned SUBFRAME_W = 8;

    localparam int unsigned COL_W  = $clog2(PANEL_W);
    localparam int unsigned ROW_W  = $clog2(PANEL_ROWS);
    localparam int unsigned SHOW_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        UPPER,
        LOWER,
        SETUP,
        CLKHI,
        BLANK,
        LATCH,
        SHOW
    } state_t;

endpackage

// File: rtl/hub75_scan_counters.sv
// Cascaded row -> subframe -> frame counters, stepped once per displayed row.
module hub75_scan_counters
    import hub75_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance_i,
    output logic [ROW_W-1:0]      row_o,
    output logic [SUBFRAME_W-1:0] subframe_o,
    output logic [FRAME_W-1:0]    frame_o
);

    logic [ROW_W-1:0]      row_q;
    logic [SUBFRAME_W-1:0] subframe_q;
    logic [FRAME_W-1:0]    frame_q;

    // NOTE: non-blocking updates let each stage test the pre-increment value of the stage below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q      <= '0;
            subframe_q <= '0;
            frame_q    <= '0;
        end else if (advance_i) begin
            row_q <= row_q + 1'b1;
            if (row_q == ROW_W'(PANEL_ROWS - 1)) begin
                subframe_q <= subframe_q + 1'b1;
                if (subframe_q == '1) begin
                    frame_q <= frame_q + 1'b1;
                end
            end
        end
    end

    assign row_o      = row_q;
    assign subframe_o = subframe_q;
    assign frame_o    = frame_q;

endmodule

// File: rtl/hub75_scanner.sv
// HUB75 64x64 scanner: drives the painter, shifts both panel halves, latches and shows each row pair.
// Optional macro HUB75_SCANNER_DIM_EN adds a brightness input that shortens the lit part of SHOW.
module hub75_scanner
    import hub75_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
`ifdef HUB75_SCANNER_DIM_EN
    input  logic [7:0]  brightness,
`endif
    input  logic [2:0]  rgb,
    output logic [5:0]  x,
    output logic [5:0]  y,
    output logic [12:0] frame,
    output logic [7:0]  subframe,
    output logic [2:0]  hub_rgb0,
    output logic [2:0]  hub_rgb1,
    output logic [4:0]  hub_addr,
    output logic        hub_clk,
    output logic        hub_lat,
    output logic        hub_oe_n,
    output logic        frame_start
);

    state_t            state_q;
    logic [COL_W-1:0]  col_q;
    logic [2:0]        upper_q;
    logic [SHOW_W-1:0] show_cnt_q;
    logic [5:0]        x_q, y_q;
    logic [2:0]        hub_rgb0_q, hub_rgb1_q;
    logic [4:0]        hub_addr_q;
    logic              hub_clk_q, hub_lat_q, hub_oe_n_q, frame_start_q;

    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col_d;
    logic [ROW_W-1:0]  row_d;
    logic              show_last;
    logic              advance;

    assign col_d     = col_q + 1'b1;
    assign row_d     = row + 1'b1;
    assign show_last = (show_cnt_q == SHOW_W'(SHOW_CYCLES - 1));
    assign advance   = (state_q == SHOW) && show_last;

    hub75_scan_counters u_counters (
        .clk        (clk),
        .rst_n      (reset),
        .advance_i  (advance),
        .row_o      (row),
        .subframe_o (subframe),
        .frame_o    (frame)
    );

`ifdef HUB75_SCANNER_DIM_EN
    logic [19:0]       dim_prod;
    logic [SHOW_W-1:0] on_cycles;
    logic [SHOW_W-1:0] on_q;

    assign dim_prod  = 20'(brightness) * 20'(SHOW_CYCLES);
    assign on_cycles = SHOW_W'(dim_prod >> 8);
`endif

    // NOTE: the asynchronous clear raises hub_oe_n without waiting for a clock, blanking the panel at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            col_q         <= '0;
            upper_q       <= '0;
            show_cnt_q    <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hub_rgb0_q    <= '0;
            hub_rgb1_q    <= '0;
            hub_addr_q    <= '0;
            hub_clk_q     <= 1'b0;
            hub_lat_q     <= 1'b0;
            hub_oe_n_q    <= 1'b1;
            frame_start_q <= 1'b0;
`ifdef HUB75_SCANNER_DIM_EN
            on_q          <= '0;
`endif
        end else begin
            frame_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q       <= UPPER;
                        x_q           <= col_q;
                        y_q           <= {1'b0, row};
                        frame_start_q <= (row == '0);
                    end
                end
                UPPER: begin
                    upper_q <= rgb;
                    y_q     <= {1'b1, row};
                    state_q <= LOWER;
                end
                LOWER: begin
                    hub_rgb0_q <= upper_q;
                    hub_rgb1_q <= rgb;
                    state_q    <= SETUP;
                end
                SETUP: begin
                    hub_clk_q <= 1'b1;
                    state_q   <= CLKHI;
                end
                CLKHI: begin
                    hub_clk_q <= 1'b0;
                    col_q     <= col_d;
                    if (col_q == COL_W'(PANEL_W - 1)) begin
                        hub_addr_q <= row;
                        state_q    <= BLANK;
                    end else begin
                        x_q     <= col_d;
                        y_q     <= {1'b0, row};
                        state_q <= UPPER;
                    end
                end
                BLANK: begin
                    hub_lat_q <= 1'b1;
                    state_q   <= LATCH;
                end
                LATCH: begin
                    hub_lat_q  <= 1'b0;
                    show_cnt_q <= '0;
                    state_q    <= SHOW;
`ifdef HUB75_SCANNER_DIM_EN
                    on_q       <= on_cycles;
                    hub_oe_n_q <= (on_cycles == '0);
`else
                    hub_oe_n_q <= 1'b0;
`endif
                end
                SHOW: begin
                    if (show_last) begin
                        hub_oe_n_q <= 1'b1;
                        if (enable) begin
                            state_q       <= UPPER;
                            x_q           <= '0;
                            y_q           <= {1'b0, row_d};
                            frame_start_q <= (row_d == '0);
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        show_cnt_q <= show_cnt_q + 1'b1;
`ifdef HUB75_SCANNER_DIM_EN
                        hub_oe_n_q <= !((show_cnt_q + 1'b1) < on_q);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hub_rgb0    = hub_rgb0_q;
    assign hub_rgb1    = hub_rgb1_q;
    assign hub_addr    = hub_addr_q;
    assign hub_clk     = hub_clk_q;
    assign hub_lat     = hub_lat_q;
    assign hub_oe_n    = hub_oe_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hub75_scanner.sv
// Bench for hub75_scanner: random painter image, cycle-indexed row-period reference model.
module tb_hub75_scanner;

`ifdef HUB75_SCANNER_DIM_EN
    localparam int SHOW = 256;
`else
    localparam int SHOW = 4;
`endif
    localparam int ROW_PERIOD = 258 + SHOW;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  rgb;
    logic [5:0]  x, y;
    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [2:0]  hub_rgb0, hub_rgb1;
    logic [4:0]  hub_addr;
    logic        hub_clk, hub_lat, hub_oe_n, frame_start;
`ifdef HUB75_SCANNER_DIM_EN
    logic [7:0]  brightness;
`endif

    logic [2:0] paint_lut [4096];
    int n_cmp = 0;
    int n_err = 0;
    int row_m, subframe_m, frame_m, addr_m, exp_on;

    hub75_scanner #(.SHOW_CYCLES(SHOW)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
`ifdef HUB75_SCANNER_DIM_EN
        .brightness  (brightness),
`endif
        .rgb         (rgb),
        .x           (x),
        .y           (y),
        .frame       (frame),
        .subframe    (subframe),
        .hub_rgb0    (hub_rgb0),
        .hub_rgb1    (hub_rgb1),
        .hub_addr    (hub_addr),
        .hub_clk     (hub_clk),
        .hub_lat     (hub_lat),
        .hub_oe_n    (hub_oe_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Painter: a random image indexed by {y, x}.
    always_comb rgb = paint_lut[{y, x}];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Watches one full row period starting at the negedge before the row's first UPPER cycle.
    task automatic scan_row(input int drop_col);
        int r, col;
        logic [5:0] ex, ey;
        logic e_clk, e_lat, e_oe_n, e_fs;
        r = row_m;
        for (int idx = 0; idx < ROW_PERIOD; idx++) begin
            @(negedge clk);
            col    = idx / 4;
            ex     = (idx < 256) ? 6'(col) : 6'd63;
            ey     = (idx < 256 && idx % 4 == 0) ? 6'(r) : 6'(r + 32);
            e_clk  = (idx < 256) && (idx % 4 == 3);
            e_lat  = (idx == 257);
            e_oe_n = !((idx >= 258) && (idx < 258 + exp_on));
            e_fs   = (idx == 0) && (r == 0);
            if (idx == 256) addr_m = r;

            n_cmp++;
            if ({x, y} !== {ex, ey}) begin
                n_err++;
                $display("FAIL coords row %0d cyc %0d: got x=%0d y=%0d want x=%0d y=%0d", r, idx, x, y, ex, ey);
            end
            n_cmp++;
            if ({hub_clk, hub_lat, hub_oe_n, frame_start} !== {e_clk, e_lat, e_oe_n, e_fs}) begin
                n_err++;
                $display("FAIL strobes(clk,lat,oe_n,fs) row %0d cyc %0d: got %b want %b", r, idx,
                         {hub_clk, hub_lat, hub_oe_n, frame_start}, {e_clk, e_lat, e_oe_n, e_fs});
            end
            n_cmp++;
            if (hub_addr !== 5'(addr_m)) begin
                n_err++;
                $display("FAIL hub_addr row %0d cyc %0d: got %0d want %0d", r, idx, hub_addr, addr_m);
            end
            n_cmp++;
            if ({frame, subframe} !== {13'(frame_m), 8'(subframe_m)}) begin
                n_err++;
                $display("FAIL counters row %0d cyc %0d: got frame=%0d sub=%0d want frame=%0d sub=%0d",
                         r, idx, frame, subframe, frame_m, subframe_m);
            end
            if (idx < 256 && idx % 4 >= 2) begin
                n_cmp++;
                if ({hub_rgb0, hub_rgb1} !== {paint_lut[r * 64 + col], paint_lut[(r + 32) * 64 + col]}) begin
                    n_err++;
                    $display("FAIL pixel row %0d col %0d cyc %0d: got %0d/%0d want %0d/%0d", r, col, idx,
                             hub_rgb0, hub_rgb1, paint_lut[r * 64 + col], paint_lut[(r + 32) * 64 + col]);
                end
            end
            if (drop_col >= 0 && idx == drop_col * 4 + 3) enable = 1'b0;
        end
        row_m = (r + 1) % 32;
        if (row_m == 0) begin
            subframe_m = (subframe_m + 1) % 256;
            if (subframe_m == 0) frame_m = (frame_m + 1) % 8192;
        end
    endtask

    task automatic test_reset();
        logic [47:0] outs;
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        outs = {x, y, frame, subframe, hub_rgb0, hub_rgb1, hub_addr, hub_clk, hub_lat, hub_oe_n, frame_start};
        n_cmp++;
        if (outs !== 48'h2) begin
            n_err++;
            $display("FAIL reset outputs: got %h want %h", outs, 48'h2);
        end
        reset = 1'b1;
        for (int i = 0; i < 5 + int'($urandom_range(0, 7)); i++) begin
            @(negedge clk);
            n_cmp++;
            if ({hub_clk, hub_lat, hub_oe_n, frame_start} !== 4'b0010) begin
                n_err++;
                $display("FAIL idle strobes cyc %0d: got %b want 0010", i, {hub_clk, hub_lat, hub_oe_n, frame_start});
            end
        end
    endtask

    task automatic test_scan();
        enable = 1'b1;
        for (int i = 0; i < 32; i++) scan_row(-1);
    endtask

    task automatic test_subframe_wrap();
        scan_row(-1);
        force dut.u_counters.row_q = 5'd30;
        force dut.u_counters.subframe_q = 8'd255;
        #1;
        release dut.u_counters.row_q;
        release dut.u_counters.subframe_q;
        row_m      = 31;
        subframe_m = 255;
        scan_row(-1);
        scan_row(-1);
    endtask

    task automatic test_enable_drop();
        int dc;
        dc = int'($urandom_range(5, 58));
        scan_row(dc);
        for (int i = 0; i < 2 * ROW_PERIOD; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({hub_clk, hub_lat, hub_oe_n, hub_addr} !== {3'b001, 5'(addr_m)}) begin
                n_err++;
                $display("FAIL stopped(clk,lat,oe_n,addr) cyc %0d: got %b want %b", i,
                         {hub_clk, hub_lat, hub_oe_n, hub_addr}, {3'b001, 5'(addr_m)});
            end
        end
        enable = 1'b1;
        scan_row(-1);
    endtask

    task automatic test_reset_show();
        logic [47:0] outs;
        repeat (260) @(negedge clk);
        n_cmp++;
        if (hub_oe_n !== 1'b0) begin
            n_err++;
            $display("FAIL oe_n before reset: got %b want 0", hub_oe_n);
        end
        #2 reset = 1'b0;
        #1;
        outs = {x, y, frame, subframe, hub_rgb0, hub_rgb1, hub_addr, hub_clk, hub_lat, hub_oe_n, frame_start};
        n_cmp++;
        if (outs !== 48'h2) begin
            n_err++;
            $display("FAIL async reset outputs: got %h want %h", outs, 48'h2);
        end
        repeat (3) @(negedge clk);
        outs = {x, y, frame, subframe, hub_rgb0, hub_rgb1, hub_addr, hub_clk, hub_lat, hub_oe_n, frame_start};
        n_cmp++;
        if (outs !== 48'h2) begin
            n_err++;
            $display("FAIL held reset outputs: got %h want %h", outs, 48'h2);
        end
        reset      = 1'b1;
        row_m      = 0;
        subframe_m = 0;
        frame_m    = 0;
        addr_m     = 0;
        scan_row(-1);
        scan_row(-1);
    endtask

    task automatic test_frame_wrap();
        force dut.u_counters.row_q = 5'd30;
        force dut.u_counters.subframe_q = 8'd255;
        force dut.u_counters.frame_q = 13'd8191;
        #1;
        release dut.u_counters.row_q;
        release dut.u_counters.subframe_q;
        release dut.u_counters.frame_q;
        row_m      = 31;
        subframe_m = 255;
        frame_m    = 8191;
        scan_row(-1);
        scan_row(-1);
    endtask

`ifdef HUB75_SCANNER_DIM_EN
    task automatic test_dim();
        int levels [4];
        levels[0] = 64;
        levels[1] = 0;
        levels[2] = int'($urandom_range(1, 255));
        levels[3] = 255;
        for (int i = 0; i < 4; i++) begin
            brightness = 8'(levels[i]);
            exp_on     = (levels[i] * SHOW) / 256;
            scan_row(-1);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) paint_lut[i] = 3'($urandom);
        row_m      = 0;
        subframe_m = 0;
        frame_m    = 0;
        addr_m     = 0;
`ifdef HUB75_SCANNER_DIM_EN
        brightness = 8'd255;
        exp_on     = (255 * SHOW) / 256;
`else
        exp_on     = SHOW;
`endif
        test_reset();
        test_scan();
        test_subframe_wrap();
        test_enable_drop();
        test_reset_show();
        test_frame_wrap();
`ifdef HUB75_SCANNER_DIM_EN
        test_dim();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hub75_scanner.md
# hub75_scanner

Scan controller for the 64x64 HUB75 LED panel. Generates the pixel coordinates and the frame/subframe counters that drive the combinational pixel painter. Time-multiplexes the painter's single 3-bit colour output between the upper and lower panel halves, then shifts, latches and displays each of the 32 row pairs in sequence. Sits between the painter and the panel connector pins.

## Interface
- `SHOW_CYCLES`, default 512: clock cycles each latched row is displayed; legal range 1..4095.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; sampled only at row boundaries.
- `x` out 6: painter column coordinate.
- `y` out 6: painter row coordinate, 0..63.
- `frame` out 13: frame counter to the painter.
- `subframe` out 8: subframe counter to the painter.
- `rgb` in 3: painter colour {b,g,r}, combinational from `x`/`y`/`frame`/`subframe`.
- `hub_rgb0` out 3: upper-half pixel data.
- `hub_rgb1` out 3: lower-half pixel data.
- `hub_addr` out 5: displayed row-pair address.
- `hub_clk` out 1: panel shift clock.
- `hub_lat` out 1: panel latch strobe.
- `hub_oe_n` out 1: panel output enable, active-low.
- `frame_start` out 1: one-cycle pulse when row 0 of a new scan begins shifting.
- `brightness` in 8: only with `HUB75_SCANNER_DIM_EN` (see Configuration).

## Operation
- All outputs are registered.
- Reset values: every output 0, except `hub_oe_n` = 1. Internal `row` = 0, `col` = 0, state IDLE.
- **IDLE:** `hub_oe_n` = 1. Go to UPPER when `enable` = 1.
- **Per column, 4 states, cycling `col` 0..63:**
  - UPPER: `x` = `col`, `y` = `row`. Capture `rgb` into the upper register.
  - LOWER: `y` = `row` + 32. Capture `rgb` into the lower register.
  - SETUP: `hub_rgb0` / `hub_rgb1` take the captured values; `hub_clk` = 0.
  - CLKHI: `hub_clk` = 1. Then `col` increments and the state returns to UPPER. If `col` was 63, `col` wraps to 0 and the state goes to BLANK.
- **BLANK (1 cycle):** `hub_oe_n` = 1; `hub_addr` <= `row`.
- **LATCH (1 cycle):** `hub_lat` = 1; `hub_oe_n` = 1.
- **SHOW (`SHOW_CYCLES` cycles):** `hub_oe_n` = 0. On exit:
  - `row` increments, wrapping 31 -> 0.
  - On the wrap, `subframe` increments.
  - When `subframe` wraps 255 -> 0, `frame` increments; `frame` wraps modulo 2^13.
  - Next state is UPPER if `enable` = 1, else IDLE.
- `frame_start` pulses in the UPPER cycle with `row` = 0 and `col` = 0.
- `enable` dropping mid-row has no effect until the SHOW exit.
- Painter inputs change only in UPPER and LOWER. `frame` and `subframe` are constant for the whole of one 32-row scan.

## Timing
- Painter path is combinational: `rgb` must settle within one `clk` period of `x`/`y` changing.
- Panel data changes one cycle before the `hub_clk` rising edge and holds through CLKHI. This gives one cycle of setup and hold around each shift edge.
- Row period = 4·64 + 2 + `SHOW_CYCLES` = 258 + `SHOW_CYCLES` cycles.
- Full scan = 32 row periods.
- First `hub_clk` rise is 3 cycles after leaving IDLE.
- `hub_lat` never coincides with `hub_oe_n` = 0.
- `hub_addr` changes only while `hub_oe_n` = 1.
- `reset` asserted mid-operation forces the reset values immediately: `hub_oe_n` goes high asynchronously, so the panel is blanked at once.

## Configuration
- `HUB75_SCANNER_DIM_EN` defined:
  - Adds the `brightness` input.
  - During SHOW, `hub_oe_n` = 0 only while the SHOW cycle index (0-based) < `brightness`·`SHOW_CYCLES`/256, computed with a 20-bit product.
  - `brightness` is sampled in LATCH.
  - `brightness` = 0 keeps the panel dark; SHOW duration is unchanged.
- Undefined: no `brightness` port; `hub_oe_n` = 0 for all of SHOW.

## Structure
- Package `hub75_pkg` holds:
  - State enum: IDLE, UPPER, LOWER, SETUP, CLKHI, BLANK, LATCH, SHOW.
  - Constants `PANEL_W` = 64, `PANEL_ROWS` = 32, `FRAME_W` = 13, `SUBFRAME_W` = 8.
- One sub-module, `hub75_scan_counters`, holds the cascaded `row` -> `subframe` -> `frame` counters with a single advance strobe.
- The FSM and the shift/latch logic stay in `hub75_scanner`.

## Test plan
- Reset released, `enable` = 1, `SHOW_CYCLES` = 4, painter model returns {`y`[0], `x`[1], `x`[0]} -> 64 `hub_clk` rises per row. `hub_rgb0`/`hub_rgb1` match the model for `y` = `row` and `row` + 32. Row period = 262 cycles.
- 32 rows -> `hub_addr` steps 0..31, `subframe` goes 0 -> 1, `frame_start` pulses once per scan.
- Preload `subframe` to 255 via 255 scans (or force) -> after scan end `subframe` = 0, `frame` = 1. With `frame` = 8191 -> `frame` wraps to 0.
- `enable` dropped during column 20 -> row finishes, SHOW completes, then IDLE with `hub_oe_n` = 1 and no further `hub_clk` edges.
- `reset` asserted during SHOW -> `hub_oe_n` = 1 immediately and all counters 0. Scan restarts at row 0 after release.
- `HUB75_SCANNER_DIM_EN` defined, `SHOW_CYCLES` = 256, `brightness` = 64 -> 64 low `hub_oe_n` cycles per SHOW. `brightness` = 0 -> none.
